// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage that owns the PC and drives the instruction
//            memory read port. It latches the IR and decodes its fields, and it
//            uses a valid/ready handshake. Optional macro FETCH_COUNT_EN adds
//            saturating counters for accepted fetches and redirects.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W      = 32,
    parameter int                MEM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                PC_STEP     = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [15:0]       immediate,
    output logic [31:0]       fetch_count,
    output logic [31:0]       redir_count
);

    localparam int                c_LAT_W    = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(MEM_LATENCY);
    localparam logic [ADDR_W-1:0] c_STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] c_ALIGN    = ~(c_STEP - ADDR_W'(1));

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [c_LAT_W-1:0] r_lat_cnt;
    logic [c_LAT_W-1:0] w_lat_nxt;
    logic               r_fetch_valid;
    logic               w_valid_nxt;
    logic [31:0]        r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               w_ir_we;
    logic               w_accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_lat_cnt     <= '0;
            r_fetch_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_lat_cnt     <= w_lat_nxt;
            r_fetch_valid <= w_valid_nxt;
            if (w_ir_we) begin
                r_instr    <= mem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    // A redirect wins over both fetch completion and the hold handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lat_nxt   = r_lat_cnt;
        w_valid_nxt = r_fetch_valid;
        w_ir_we     = 1'b0;
        w_accept    = (r_state == S_HOLD) && r_fetch_valid && fetch_ready;
        if (pc_load) begin
            w_pc_nxt    = pc_target & c_ALIGN;
            w_lat_nxt   = '0;
            w_state_nxt = S_FETCH;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        w_ir_we     = 1'b1;
                        w_pc_nxt    = r_pc + c_STEP;
                        w_lat_nxt   = '0;
                        w_state_nxt = S_HOLD;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_lat_nxt = r_lat_cnt + c_LAT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        w_state_nxt = S_FETCH;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_redir_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_redir_count <= '0;
        end else begin
            if (w_accept && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (pc_load && (r_redir_count != 32'hFFFF_FFFF)) begin
                r_redir_count <= r_redir_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign redir_count = r_redir_count;
`else
    assign fetch_count = 32'd0;
    assign redir_count = 32'd0;
`endif

    assign mem_addr    = r_pc;
    assign mem_rd      = (r_state == S_FETCH);
    assign pc_out      = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[31:26];
    assign rs          = r_instr[25:21];
    assign rt          = r_instr[20:16];
    assign immediate   = r_instr[15:0];

endmodule
`default_nettype wire
